// File: rtl/pos_lut_sweeper_pkg.sv
// Shared types and constants for the serial-loaded truth-table evaluator.
package pos_lut_pkg;

    localparam int N_MAX = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Table width for an n-input function.
    function automatic int t_from_n(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/pos_lut_sweeper_if.sv
// Load port, sweep control, lookup path and sweep stream of pos_lut_sweeper.
interface pos_lut_sweeper_if #(
    parameter int N = 4
);
    logic         cfg_valid;
    logic         cfg_bit;
    logic         cfg_ready;
    logic         start;
    logic         busy;
    logic [N-1:0] eval_in;
    logic         eval_s;
    logic         out_valid;
    logic [N-1:0] out_idx;
    logic         out_s;
    logic         done;
    logic [N:0]   ones_count;

    modport master (
        output cfg_valid, cfg_bit, start, eval_in,
        input  cfg_ready, busy, eval_s, out_valid, out_idx, out_s, done, ones_count
    );

    modport slave (
        input  cfg_valid, cfg_bit, start, eval_in,
        output cfg_ready, busy, eval_s, out_valid, out_idx, out_s, done, ones_count
    );
endinterface

// File: rtl/pos_lut_sweeper_lut_mux.sv
// Combinational T-to-1 table read; the parent registers the result.
module lut_mux
    import pos_lut_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [t_from_n(N)-1:0] lut,
    input  logic [N-1:0]           idx,
    output logic                   s
);
    assign s = lut[idx];
endmodule

// File: rtl/pos_lut_sweeper.sv
// N-input truth-table evaluator: serial table load, registered lookup and
// self-timed exhaustive sweep that reports the number of ones.
module pos_lut_sweeper
    import pos_lut_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              reset,
    pos_lut_sweeper_if.slave  bus
);
    localparam int           T        = t_from_n(N);
    localparam logic [N-1:0] LAST_IDX = N'(T - 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_LOAD  = LOAD;
    localparam logic [1:0] S_SWEEP = SWEEP;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]   state;
    logic [T-1:0] lut_q;
    logic [T-1:0] shadow_q;
    logic [T-1:0] shadow_wr;
    logic [N-1:0] load_idx;
    logic [N-1:0] sweep_idx;
    logic [N:0]   acc;
    logic         eval_mux_s;
    logic         sweep_mux_s;

    lut_mux #(.N(N)) u_eval_mux  (.lut(lut_q), .idx(bus.eval_in), .s(eval_mux_s));
    lut_mux #(.N(N)) u_sweep_mux (.lut(lut_q), .idx(sweep_idx),   .s(sweep_mux_s));

    // Shadow with the offered bit merged in; also the value committed on the last handshake.
    always_comb begin
        shadow_wr           = shadow_q;
        shadow_wr[load_idx] = bus.cfg_bit;
    end

    assign bus.cfg_ready = (state == S_IDLE) || (state == S_LOAD);
    assign bus.busy      = (state != S_IDLE);

    // NOTE: table and shadow are plain flops, so they are cleared by reset with everything else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            lut_q          <= '0;
            shadow_q       <= '0;
            load_idx       <= '0;
            sweep_idx      <= '0;
            acc            <= '0;
            bus.eval_s     <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_idx    <= '0;
            bus.out_s      <= 1'b0;
            bus.done       <= 1'b0;
            bus.ones_count <= '0;
        end else begin
            bus.eval_s    <= eval_mux_s;
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A load request takes priority; a simultaneous start is dropped.
                    if (bus.cfg_valid) begin
                        shadow_q <= shadow_wr;
                        load_idx <= load_idx + N'(1);
                        state    <= S_LOAD;
                    end else if (bus.start) begin
                        sweep_idx <= '0;
                        acc       <= '0;
                        state     <= S_SWEEP;
                    end
                end
                S_LOAD: begin
                    if (bus.cfg_valid) begin
                        shadow_q <= shadow_wr;
                        load_idx <= load_idx + N'(1);
                        if (load_idx == LAST_IDX) begin
                            lut_q    <= shadow_wr;
                            load_idx <= '0;
                            state    <= S_IDLE;
                        end
                    end
                end
                S_SWEEP: begin
                    bus.out_valid <= 1'b1;
                    bus.out_idx   <= sweep_idx;
                    bus.out_s     <= sweep_mux_s;
                    acc           <= acc + (N+1)'(sweep_mux_s);
                    sweep_idx     <= sweep_idx + N'(1);
                    if (sweep_idx == LAST_IDX) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    bus.done       <= 1'b1;
                    bus.ones_count <= acc;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pos_lut_sweeper.sv
// Directed and randomized bench for pos_lut_sweeper against a table-level reference model.
module tb_pos_lut_sweeper;
    import pos_lut_pkg::*;

    localparam int N = 4;
    localparam int T = t_from_n(N);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pos_lut_sweeper_if #(.N(N)) bus ();

    pos_lut_sweeper #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [T-1:0] model_lut;
    int           errors = 0;
    int           checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serially load v from bit index 'first'; probe shows the table switch over on eval_s.
    task automatic load_table(input logic [T-1:0] v, input bit gaps,
                              input logic [N-1:0] probe, input int first);
        logic old_bit;
        old_bit     = model_lut[probe];
        bus.eval_in = probe;
        for (int i = first; i < T; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            check("cfg_ready_load", 32'(bus.cfg_ready), 32'd1);
            bus.cfg_valid = 1'b1;
            bus.cfg_bit   = v[i];
            tick();
            bus.cfg_valid = 1'b0;
        end
        model_lut = v;
        check("load_back_idle", 32'(bus.busy), 32'd0);
        check("eval_at_commit_old", 32'(bus.eval_s), 32'(old_bit));
        tick();
        check("eval_after_commit_new", 32'(bus.eval_s), 32'(model_lut[probe]));
    endtask

    task automatic run_sweep(input bit poke_start);
        int   idx_q[$];
        logic s_q[$];
        int   cnt;
        bit   seen;
        logic [N:0] expect_ones;
        cnt  = 0;
        seen = 1'b0;
        expect_ones = (N+1)'($countones(model_lut));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("sweep_busy", 32'(bus.busy), 32'd1);
        check("sweep_first_gap", 32'(bus.out_valid), 32'd0);
        while (!seen && cnt < 4 * T) begin
            if (poke_start) bus.start = (cnt == 3);
            tick();
            cnt++;
            if (bus.done) seen = 1'b1;
            else check("cfg_ready_sweep", 32'(bus.cfg_ready), 32'd0);
            if (bus.out_valid) begin
                idx_q.push_back(int'(bus.out_idx));
                s_q.push_back(bus.out_s);
            end
        end
        bus.start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        check("sweep_len", 32'(cnt + 1), 32'(T + 2));
        check("sample_count", 32'(idx_q.size()), 32'(T));
        for (int k = 0; k < idx_q.size() && k < T; k++) begin
            check("sample_idx", 32'(idx_q[k]), 32'(k));
            check("sample_s", 32'(s_q[k]), 32'(model_lut[k]));
        end
        check("done_out_valid", 32'(bus.out_valid), 32'd0);
        check("ones_count", 32'(bus.ones_count), 32'(expect_ones));
        repeat (3) begin
            tick();
            check("done_single", 32'(bus.done), 32'd0);
            check("idle_after_sweep", 32'(bus.busy), 32'd0);
            check("no_extra_samples", 32'(bus.out_valid), 32'd0);
        end
        check("ones_count_held", 32'(bus.ones_count), 32'(expect_ones));
    endtask

    task automatic random_evals(input int n);
        logic [N-1:0] idx;
        for (int i = 0; i < n; i++) begin
            idx         = N'($urandom_range(0, T - 1));
            bus.eval_in = idx;
            tick();
            check("eval_rand", 32'(bus.eval_s), 32'(model_lut[idx]));
        end
    endtask

    initial begin
        logic [T-1:0] rnd;
        bus.cfg_valid = 1'b0;
        bus.cfg_bit   = 1'b0;
        bus.start     = 1'b0;
        bus.eval_in   = '0;
        model_lut     = '0;
        reset         = 1'b1;
        repeat (2) tick();

        check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_eval_s", 32'(bus.eval_s), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_idx", 32'(bus.out_idx), 32'd0);
        check("rst_out_s", 32'(bus.out_s), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_ones_count", 32'(bus.ones_count), 32'd0);
        reset = 1'b0;
        tick();

        // Sweep of the reset table.
        run_sweep(1'b0);

        // Known table, then the directed lookups.
        load_table(16'hAC3C, 1'b0, 4'd2, 0);
        run_sweep(1'b0);
        check("ones_ac3c", 32'(bus.ones_count), 32'd8);
        bus.eval_in = 4'd5;
        tick();
        check("eval_5", 32'(bus.eval_s), 32'd1);
        bus.eval_in = 4'd6;
        tick();
        check("eval_6", 32'(bus.eval_s), 32'd0);
        bus.eval_in = 4'd15;
        tick();
        check("eval_15", 32'(bus.eval_s), 32'd1);
        random_evals(8);

        // All-ones table loaded with gaps; count must reach T without overflow.
        load_table(16'hFFFF, 1'b1, 4'd0, 0);
        run_sweep(1'b0);
        check("ones_ffff", 32'(bus.ones_count), 32'd16);

        // Reset mid-sweep: count cleared, no done.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        #1;
        check("rst_sweep_ones", 32'(bus.ones_count), 32'd0);
        check("rst_sweep_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sweep_busy", 32'(bus.busy), 32'd0);
        tick();
        reset = 1'b0;
        model_lut = '0;
        repeat (T + 3) begin
            tick();
            check("rst_sweep_no_done", 32'(bus.done), 32'd0);
        end

        // Reset after 7 load bits: partial shadow discarded, table stays 0.
        load_table(16'hFFFF, 1'b0, 4'd0, 0);
        for (int i = 0; i < 7; i++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_bit   = 1'b1;
            tick();
        end
        bus.cfg_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_load_busy", 32'(bus.busy), 32'd0);
        tick();
        reset = 1'b0;
        model_lut = '0;
        random_evals(4);
        load_table(16'h0001, 1'b0, 4'd0, 0);
        run_sweep(1'b0);

        // Simultaneous start and cfg_valid in IDLE: load wins.
        rnd = T'($urandom);
        bus.cfg_valid = 1'b1;
        bus.cfg_bit   = rnd[0];
        bus.start     = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b0;
        check("both_busy", 32'(bus.busy), 32'd1);
        check("both_in_load", 32'(bus.cfg_ready), 32'd1);
        repeat (3) begin
            check("both_no_valid", 32'(bus.out_valid), 32'd0);
            tick();
        end
        load_table(rnd, 1'b1, N'($urandom_range(0, T - 1)), 1);
        random_evals(6);
        run_sweep(1'b1);

        // One more random table and sweep.
        rnd = T'($urandom);
        load_table(rnd, 1'b1, N'($urandom_range(0, T - 1)), 0);
        random_evals(6);
        run_sweep(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
